// File: rtl/spi_master_link.sv
// SPI mode-0 master for the ALU slave board: shifts {A,B,op,pad,readback} out on MOSI
// and captures the returned ALU result nibble from MISO within the same 24-bit frame.
module spi_master_link #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [1:0] op,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic       SCLK,
   output logic       CS,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

   localparam int CW = 16;
   localparam logic [CW-1:0] DIV_RL   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_RL = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_RL  = CW'(CS_HOLD - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [22:0]   tx_q, tx_d;
   logic [3:0]    rx_q, rx_d;
   logic          sclk_q, sclk_d;
   logic          cs_q, cs_d;
   logic          mosi_q, mosi_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [3:0]    result_q, result_d;

   // Next-state and registered-output logic for the frame sequencer.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      sclk_d   = sclk_q;
      cs_d     = cs_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               // Bit 23 goes straight onto MOSI; tx_q holds the remaining 23 bits.
               tx_d    = {A[2:0], B, op, 6'b000000, 8'h00};
               mosi_d  = A[3];
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = SETUP_RL;
               bit_d   = 5'd23;
               rx_d    = 4'h0;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = DIV_RL;
               state_d = XFER;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         XFER: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!sclk_q) begin
               // Only the low nibble of the readback byte is ever reported.
               sclk_d = 1'b1;
               rx_d   = {rx_q[2:0], MISO};
               cnt_d  = DIV_RL;
            end else begin
               sclk_d = 1'b0;
               if (bit_q == 5'd0) begin
                  mosi_d  = 1'b0;
                  cnt_d   = HOLD_RL;
                  state_d = HOLD;
               end else begin
                  bit_d  = bit_q - 5'd1;
                  mosi_d = tx_q[22];
                  tx_d   = {tx_q[21:0], 1'b0};
                  cnt_d  = DIV_RL;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               cs_d     = 1'b1;
               mosi_d   = 1'b0;
               done_d   = 1'b1;
               result_d = rx_q;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= 5'd0;
         tx_q     <= 23'd0;
         rx_q     <= 4'h0;
         sclk_q   <= 1'b0;
         cs_q     <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 4'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         mosi_q   <= mosi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign SCLK   = sclk_q;
   assign CS     = cs_q;
   assign MOSI   = mosi_q;

endmodule
